// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder: byte-addressed little-endian array,
// store commits at acceptance, load data returned after a programmable latency.

module dmem_byte_lane #(
    parameter int ADDR_WIDTH = 12,
    parameter int LANE       = 0
) (
    input  logic [ADDR_WIDTH-1:0] base,
    input  logic [1:0]            size,
    input  logic                  store_en,
    input  logic [31:0]           wdata,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  we,
    output logic [7:0]            wbyte
);
    logic [2:0] nbytes;

    always_comb begin
        case (size)
            2'b00:   nbytes = 3'd1;
            2'b01:   nbytes = 3'd2;
            default: nbytes = 3'd4;
        endcase
    end

    // Lane address wraps modulo the decoded array size.
    assign addr  = base + ADDR_WIDTH'(LANE);
    assign we    = store_en && (LANE < int'(nbytes));
    assign wbyte = wdata[8*LANE +: 8];
endmodule

module dmem_responder #(
    parameter int ADDR_WIDTH = 12,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);
    localparam int NUM_LANES = 4;
    localparam int DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [3:0] CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    state_t state, state_n;
    logic [3:0] cnt, cnt_n;
    resp_t hold_q, hold_n;

    logic [7:0] mem [0:DEPTH-1];

    logic accept, mis_err, store_en;
    logic [NUM_LANES-1:0][ADDR_WIDTH-1:0] lane_addr;
    logic [NUM_LANES-1:0]                 lane_we;
    logic [NUM_LANES-1:0][7:0]            lane_wbyte;
    logic [NUM_LANES-1:0][7:0]            rbyte;
    logic [31:0] ld_data;

    assign accept   = (state == IDLE) && req_valid;
    assign mis_err  = (req_size == 2'b11) ||
                      (req_size == 2'b01 && req_addr[0]) ||
                      (req_size == 2'b10 && req_addr[1:0] != 2'b00);
    assign store_en = accept && req_write && !mis_err;

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        dmem_byte_lane #(.ADDR_WIDTH(ADDR_WIDTH), .LANE(l)) u_lane (
            .base     (req_addr[ADDR_WIDTH-1:0]),
            .size     (req_size),
            .store_en (store_en),
            .wdata    (req_wdata),
            .addr     (lane_addr[l]),
            .we       (lane_we[l]),
            .wbyte    (lane_wbyte[l])
        );
        assign rbyte[l] = mem[lane_addr[l]];
    end

    // Array has no reset: contents survive a reset pulse.
    always_ff @(posedge clk) begin
        for (int l = 0; l < NUM_LANES; l++) begin
            if (lane_we[l]) mem[lane_addr[l]] <= lane_wbyte[l];
        end
    end

    always_comb begin
        ld_data = {rbyte[3], rbyte[2], rbyte[1], rbyte[0]};
        case (req_size)
            2'b00: ld_data = req_unsigned ? {24'b0, rbyte[0]}
                                          : {{24{rbyte[0][7]}}, rbyte[0]};
            2'b01: ld_data = req_unsigned ? {16'b0, rbyte[1], rbyte[0]}
                                          : {{16{rbyte[1][7]}}, rbyte[1], rbyte[0]};
            default: ;
        endcase
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        hold_n  = hold_q;
        case (state)
            IDLE: if (accept) begin
                state_n      = (LATENCY == 1) ? RESP : BUSY;
                cnt_n        = CNT_INIT;
                hold_n.err   = mis_err;
                hold_n.rdata = (mis_err || req_write) ? 32'b0 : ld_data;
            end
            BUSY: begin
                if (cnt == 4'd0) state_n = RESP;
                else             cnt_n   = cnt - 4'd1;
            end
            RESP: if (resp_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Handshake outputs are flopped from next-state so nothing is combinational.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            hold_q     <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            hold_q     <= hold_n;
            req_ready  <= (state_n == IDLE);
            resp_valid <= (state_n == RESP);
        end
    end

    assign resp_rdata = hold_q.rdata;
    assign resp_err   = hold_q.err;
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench: three responders (latency 2, 4, 1) driven by directed vectors;
// a negedge monitor pops expected responses as they are consumed.

module tb_dmem_responder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst          [3];
    logic        req_valid    [3];
    logic        req_ready    [3];
    logic [31:0] req_addr     [3];
    logic        req_write    [3];
    logic [1:0]  req_size     [3];
    logic        req_unsigned [3];
    logic [31:0] req_wdata    [3];
    logic        resp_valid   [3];
    logic        resp_ready   [3];
    logic [31:0] resp_rdata   [3];
    logic        resp_err     [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 2 : ((g == 1) ? 4 : 1);
        dmem_responder #(.ADDR_WIDTH(12), .LATENCY(LAT)) u_dut (
            .clk          (clk),
            .reset        (rst[g]),
            .req_valid    (req_valid[g]),
            .req_ready    (req_ready[g]),
            .req_addr     (req_addr[g]),
            .req_write    (req_write[g]),
            .req_size     (req_size[g]),
            .req_unsigned (req_unsigned[g]),
            .req_wdata    (req_wdata[g]),
            .resp_valid   (resp_valid[g]),
            .resp_ready   (resp_ready[g]),
            .resp_rdata   (resp_rdata[g]),
            .resp_err     (resp_err[g])
        );
    end

    typedef struct {
        int          d;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cyc [3];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat_of(input int d);
        return (d == 0) ? 2 : ((d == 1) ? 4 : 1);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: a response is consumed at the next rising edge when valid && ready.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (!rst[d] && resp_valid[d] && resp_ready[d]) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_resp dut%0d: got %h/%0b expected none", d, resp_rdata[d], resp_err[d]);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (e.d != d || resp_rdata[d] !== e.rdata || resp_err[d] !== e.err) begin
                        errors++;
                        $display("FAIL resp dut%0d: got %h err %0b expected dut%0d %h err %0b",
                                 d, resp_rdata[d], resp_err[d], e.d, e.rdata, e.err);
                    end
                end
            end
        end
    end

    task automatic wait_ready(input int d);
        int n = 0;
        while (req_ready[d] !== 1'b1 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 50) chk("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic drive(input int d, input logic w, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd);
        req_valid[d]    = 1'b1;
        req_write[d]    = w;
        req_size[d]     = sz;
        req_unsigned[d] = uns;
        req_addr[d]     = addr;
        req_wdata[d]    = wd;
    endtask

    task automatic issue(input int d, input logic w, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic exp_err,
                         input bit hold, input string name);
        int lat;
        wait_ready(d);
        exp_q.push_back('{d, exp_rd, exp_err});
        if (hold) resp_ready[d] = 1'b0;
        drive(d, w, sz, uns, addr, wd);
        @(posedge clk); #1;
        acc_cyc[d] = cyc;
        req_valid[d] = 1'b0;
        req_addr[d]  = 32'hxxxx_xxxx;
        chk({name, " rdy_low"}, {31'b0, req_ready[d]}, 32'd0);
        lat = 1;
        while (resp_valid[d] !== 1'b1 && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        chk({name, " latency"}, lat, lat_of(d));
        if (hold) begin
            for (int i = 0; i < 3; i++) begin
                drive(d, 1'b1, 2'b10, 1'b0, 32'h10, 32'h0);
                @(posedge clk); #1;
                chk({name, " bp_valid"}, {31'b0, resp_valid[d]}, 32'd1);
                chk({name, " bp_rdata"}, resp_rdata[d], exp_rd);
                chk({name, " bp_rdy"}, {31'b0, req_ready[d]}, 32'd0);
            end
            req_valid[d]  = 1'b0;
            resp_ready[d] = 1'b1;
            @(posedge clk); #1;
            chk({name, " bp_drop"}, {31'b0, resp_valid[d]}, 32'd0);
            chk({name, " bp_idle"}, {31'b0, req_ready[d]}, 32'd1);
        end
    endtask

    task automatic check_reset_vals(input int d, input string name);
        chk({name, " req_ready"}, {31'b0, req_ready[d]}, 32'd1);
        chk({name, " resp_valid"}, {31'b0, resp_valid[d]}, 32'd0);
        chk({name, " resp_rdata"}, resp_rdata[d], 32'd0);
        chk({name, " resp_err"}, {31'b0, resp_err[d]}, 32'd0);
    endtask

    // Accept a request, then pulse reset one cycle later while still busy.
    task automatic reset_mid(input int d, input logic w, input logic [31:0] addr,
                             input logic [31:0] wd, input string name);
        wait_ready(d);
        drive(d, w, 2'b10, 1'b0, addr, wd);
        @(posedge clk); #1;
        req_valid[d] = 1'b0;
        @(posedge clk); #1;
        chk({name, " busy"}, {31'b0, req_ready[d]}, 32'd0);
        rst[d] = 1'b1;
        #1;
        check_reset_vals(d, name);
        @(posedge clk); #1;
        rst[d] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int p;
        for (int d = 0; d < 3; d++) begin
            rst[d] = 1'b1;
            resp_ready[d] = 1'b1;
            drive(d, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
            req_valid[d] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) check_reset_vals(d, $sformatf("rst%0d", d));
        for (int d = 0; d < 3; d++) rst[d] = 1'b0;

        // Latency 2: basic store/load, extension, errors, backpressure.
        issue(0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0, 0, "st_w10");
        p = acc_cyc[0];
        issue(0, 0, 2'b10, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 0, "ld_w10");
        chk("spacing_l2", acc_cyc[0] - p, 32'd3);
        issue(0, 1, 2'b00, 0, 32'h20, 32'h5A, 32'h0, 0, 0, "st_b20");
        issue(0, 1, 2'b00, 0, 32'h21, 32'hFFFFFF80, 32'h0, 0, 0, "st_b21");
        issue(0, 0, 2'b00, 0, 32'h21, 32'h0, 32'hFFFFFF80, 0, 0, "ld_bs21");
        issue(0, 0, 2'b00, 1, 32'h21, 32'h0, 32'h00000080, 0, 0, "ld_bu21");
        issue(0, 0, 2'b00, 0, 32'h20, 32'h0, 32'h0000005A, 0, 0, "ld_bs20");
        issue(0, 0, 2'b01, 0, 32'h20, 32'h0, 32'hFFFF805A, 0, 0, "ld_hs20");
        issue(0, 0, 2'b01, 1, 32'h20, 32'h0, 32'h0000805A, 0, 0, "ld_hu20");
        issue(0, 1, 2'b01, 0, 32'h22, 32'hABCD1234, 32'h0, 0, 0, "st_h22");
        issue(0, 0, 2'b10, 0, 32'h20, 32'h0, 32'h1234805A, 0, 0, "ld_w20");
        issue(0, 0, 2'b01, 0, 32'h13, 32'h0, 32'h0, 1, 0, "ld_h13_err");
        issue(0, 0, 2'b10, 0, 32'h12, 32'h0, 32'h0, 1, 0, "ld_w12_err");
        issue(0, 0, 2'b11, 0, 32'h0, 32'h0, 32'h0, 1, 0, "ld_sz3_err");
        issue(0, 1, 2'b10, 0, 32'h12, 32'hCAFEF00D, 32'h0, 1, 0, "st_w12_err");
        issue(0, 1, 2'b01, 0, 32'h11, 32'h0000CAFE, 32'h0, 1, 0, "st_h11_err");
        issue(0, 1, 2'b11, 0, 32'h10, 32'h01020304, 32'h0, 1, 0, "st_sz3_err");
        issue(0, 0, 2'b10, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 0, "ld_w10_keep");
        issue(0, 0, 2'b01, 0, 32'h12, 32'h0, 32'hFFFFDEAD, 0, 0, "ld_hs12");
        issue(0, 0, 2'b10, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 1, "bp");
        issue(0, 0, 2'b10, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 0, "ld_w10_post_bp");

        // Latency 4: reset while busy drops the response but keeps the store.
        issue(1, 1, 2'b10, 0, 32'h44, 32'h0BADF00D, 32'h0, 0, 0, "st_w44");
        reset_mid(1, 1'b1, 32'h40, 32'h12345678, "rst_st");
        issue(1, 0, 2'b10, 0, 32'h40, 32'h0, 32'h12345678, 0, 0, "ld_w40");
        reset_mid(1, 1'b0, 32'h44, 32'h0, "rst_ld");
        issue(1, 0, 2'b10, 0, 32'h44, 32'h0, 32'h0BADF00D, 0, 0, "ld_w44");

        // Latency 1: upper address bits ignored, 2-cycle request spacing.
        issue(2, 1, 2'b10, 0, 32'h1004, 32'hA5A55A5A, 32'h0, 0, 0, "st_w1004");
        p = acc_cyc[2];
        issue(2, 0, 2'b10, 0, 32'h0004, 32'h0, 32'hA5A55A5A, 0, 0, "ld_w0004");
        chk("spacing_l1", acc_cyc[2] - p, 32'd2);
        p = acc_cyc[2];
        issue(2, 0, 2'b00, 1, 32'h1007, 32'h0, 32'h000000A5, 0, 0, "ld_bu1007");
        chk("spacing_l1b", acc_cyc[2] - p, 32'd2);

        for (int d = 0; d < 3; d++) wait_ready(d);
        @(posedge clk); #1;
        chk("queue_empty", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Memory-side responder for the CPU data-memory port. It accepts one load or store request at a time over a valid/ready handshake and performs the access on an internal byte-addressed, little-endian array. After a fixed, programmable latency it returns a response that carries sign- or zero-extended load data and a misalignment error flag. The block sits behind the core's load/store stage and replaces the zero-latency data memory when the core moves to a stall-on-memory pipeline.

## Interface
Parameters:
- ADDR_WIDTH, 12: byte-address bits actually decoded. Array size is 2^ADDR_WIDTH bytes.
- LATENCY, 2: cycles from request acceptance to resp_valid. Legal range is 1..15.

Ports. One clock; reset is asynchronous and active-high.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request
- req_addr  in  32  byte address; only bits [ADDR_WIDTH-1:0] are used
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend
- req_wdata  in  32  store data, LSB-aligned
- resp_valid  out  1  response present
- resp_ready  in  1  requester consumes the response
- resp_rdata  out  32  formatted load data; 0 for stores and errors
- resp_err  out  1  misaligned access or illegal size

## Operation
- FSM states:
  - IDLE: req_ready=1.
  - BUSY: counting down the latency.
  - RESP: resp_valid=1.
- IDLE→BUSY on an edge where req_valid && req_ready. The request is accepted at that edge.
  - If LATENCY=1, the transition is IDLE→RESP directly.
- At the accepting edge:
  - Compute the error: size=01 with addr[0]=1; size=10 with addr[1:0]≠0; or size=11.
  - If there is no error and req_write=1, commit the store to the array at this edge.
    - byte: wdata[7:0] → A.
    - half: wdata[7:0] → A, wdata[15:8] → A+1.
    - word: four bytes, little-endian.
  - If there is no error and req_write=0, read, extend and register the data into the response holding register.
    - byte: sign/zero-extend bits [7:0].
    - half: sign/zero-extend bits [15:0].
    - word: unmodified.
  - On error, nothing is written, and resp_rdata=0, resp_err=1.
  - Stores return resp_rdata=0, resp_err=0.
- Address wrap: A+1..A+3 are formed modulo 2^ADDR_WIDTH. Aligned accesses never cross the top, so wrap only affects upper ignored bits.
- BUSY: the counter is loaded with LATENCY-2 and decrements each cycle. At 0, go to RESP.
- RESP: hold resp_valid, resp_rdata and resp_err stable until an edge with resp_ready=1. Then go to IDLE.
- Only one outstanding request. req_ready=0 in BUSY and RESP. req_valid is ignored there.
- Inputs other than req_valid need only be valid at the accepting edge. They are registered internally.
- Reset, at any time including mid-BUSY or mid-RESP:
  - Go to IDLE and drop the pending response.
  - A store already committed at its accepting edge stays committed.
  - Array contents are never cleared by reset.

## Timing
- Reset values: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, state=IDLE, counter=0.
- Accept at edge k: resp_valid rises after edge k+LATENCY-1. With LATENCY=1 it is high in the cycle immediately after edge k.
- Response consumed at edge m: resp_valid=0 and req_ready=1 after edge m.
- Minimum request spacing is LATENCY+1 cycles, with resp_ready held high.
- A resp_ready that is already high when resp_valid rises consumes the response at the first edge of RESP.
- All outputs are registered. There is no combinational path from req_* or resp_ready to any output.
- Store-then-load to the same address always returns the new data, because the store commits at acceptance.

## Test plan
- LATENCY=2: store word 0xDEADBEEF @0x10, then load word @0x10 → resp_valid 2 cycles after each accept; rdata=0xDEADBEEF, err=0; store resp rdata=0.
- Store byte 0x80 @0x21; load byte signed @0x21 → 0xFFFFFF80; load byte unsigned → 0x00000080; load half signed @0x20 → 0xFFFF80xx, matching prior contents.
- Load half @0x13, load word @0x12, size=11 @0x0 → each resp_err=1, rdata=0; a following word load @0x10 is unchanged, showing no write occurred.
- Backpressure: resp_ready=0 for 3 cycles in RESP → resp_valid/rdata stable, req_ready=0, and an extra req_valid is ignored; resp_ready=1 → IDLE, req_ready=1 next cycle.
- Assert reset one cycle after accepting a store of 0x12345678 @0x40 (LATENCY=4) → outputs go to reset values immediately; after release, a load @0x40 returns 0x12345678.
- LATENCY=1, ADDR_WIDTH=12: store @0x1004, load @0x0004 → same data (wrap); resp_valid in the cycle right after each accept; back-to-back spacing is 2 cycles.
